// File: rtl/multi_edge_pulse.sv
// multi_edge_pulse: per-channel synchroniser, debounce filter, selectable edge detector and
// retriggerable pulse stretcher.
// Optional feature: define EDGE_COUNT_EN to add a saturating per-channel event counter (ev_cnt).
module multi_edge_pulse #(
  parameter int unsigned CH           = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned PULSE_LEN    = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       din,
  input  logic [2*CH-1:0]     mode,
  input  logic                clr,
  output logic [CH-1:0]       level,
  output logic [CH-1:0]       pulse,
  output logic [CH-1:0]       busy
`ifdef EDGE_COUNT_EN
  ,
  output logic [CH*CNT_W-1:0] ev_cnt
`endif
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned SW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [DW-1:0] DLast = DW'(DEBOUNCE_CYC - 1);
  localparam logic [SW-1:0] SLoad = SW'(PULSE_LEN - 1);

  if (CH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || PULSE_LEN < 1 || CNT_W < 1) begin : g_bad
    $error("multi_edge_pulse: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
  logic [CH-1:0]                  s;
  logic [CH-1:0]                  level_q, level_d;
  logic [DW-1:0]                  dcnt_q [CH];
  logic [DW-1:0]                  dcnt_d [CH];
  logic [CH-1:0]                  upd;
  logic [CH-1:0]                  ev;
  logic [CH-1:0]                  act_q, act_d;
  logic [SW-1:0]                  scnt_q [CH];
  logic [SW-1:0]                  scnt_d [CH];

  // Synchroniser: stage 0 samples din, the last stage feeds the debouncer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce: accept s once it has differed from level for DEBOUNCE_CYC consecutive cycles.
  always_comb begin
    level_d = level_q;
    upd     = '0;
    for (int i = 0; i < CH; i++) begin
      dcnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (dcnt_q[i] == DLast) begin
          level_d[i] = s[i];
          upd[i]     = 1'b1;
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edge qualification: mode is looked at on the same edge the level changes.
  always_comb begin
    ev = '0;
    for (int i = 0; i < CH; i++) begin
      case (mode[2*i +: 2])
        2'b00:   ev[i] = upd[i] & level_d[i];
        2'b01:   ev[i] = upd[i] & ~level_d[i];
        2'b10:   ev[i] = upd[i];
        default: ev[i] = 1'b0;
      endcase
    end
  end

  // Stretcher: clr beats ev; ev (re)loads the counter; otherwise count down then drop.
  always_comb begin
    act_d = act_q;
    for (int i = 0; i < CH; i++) begin
      scnt_d[i] = scnt_q[i];
      if (clr) begin
        act_d[i]  = 1'b0;
        scnt_d[i] = '0;
      end else if (ev[i]) begin
        act_d[i]  = 1'b1;
        scnt_d[i] = SLoad;
      end else if (act_q[i]) begin
        if (scnt_q[i] != '0) begin
          scnt_d[i] = scnt_q[i] - 1'b1;
        end else begin
          act_d[i] = 1'b0;
        end
      end
    end
  end

  // State registers for debounce and stretcher.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= '0;
      act_q   <= '0;
      for (int i = 0; i < CH; i++) begin
        dcnt_q[i] <= '0;
        scnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      act_q   <= act_d;
      for (int i = 0; i < CH; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        scnt_q[i] <= scnt_d[i];
      end
    end
  end

  assign level = level_q;
  assign pulse = act_q;
  assign busy  = act_q;

`ifdef EDGE_COUNT_EN
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];

  // Event counter: saturates at all-ones; clr wins over a coincident event.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (ev[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cnt_out
    assign ev_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_multi_edge_pulse.sv
// Directed bench for multi_edge_pulse: three instances differing only in PULSE_LEN
// (1, 3, 8), plus a CNT_W=3 instance when EDGE_COUNT_EN is defined.
module tb_multi_edge_pulse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic [7:0] mode;
  logic       clr;

  logic [3:0] lvl1, pul1, bsy1;
  logic [3:0] lvl3, pul3, bsy3;
  logic [3:0] lvl8, pul8, bsy8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef EDGE_COUNT_EN
  logic [31:0] cnt1, cnt3, cnt8;
  logic [3:0]  lvlc, pulc, bsyc;
  logic [11:0] cntc;
`endif

  multi_edge_pulse dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .clr(clr),
    .level(lvl1), .pulse(pul1), .busy(bsy1)
`ifdef EDGE_COUNT_EN
    , .ev_cnt(cnt1)
`endif
  );

  multi_edge_pulse #(.PULSE_LEN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .clr(clr),
    .level(lvl3), .pulse(pul3), .busy(bsy3)
`ifdef EDGE_COUNT_EN
    , .ev_cnt(cnt3)
`endif
  );

  multi_edge_pulse #(.PULSE_LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .clr(clr),
    .level(lvl8), .pulse(pul8), .busy(bsy8)
`ifdef EDGE_COUNT_EN
    , .ev_cnt(cnt8)
`endif
  );

`ifdef EDGE_COUNT_EN
  multi_edge_pulse #(.CNT_W(3)) dutc (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .clr(clr),
    .level(lvlc), .pulse(pulc), .busy(bsyc), .ev_cnt(cntc)
  );
`endif

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din   = '0;
    mode  = 8'b11_10_00_00;
    clr   = 1'b0;
    step(2);
    check("rst_level", 32'(lvl1), 32'h0);
    check("rst_pulse", 32'(pul1), 32'h0);
    check("rst_busy",  32'(bsy1), 32'h0);
    rst_n = 1'b1;
    step(2);

    // 1: ch0 rise, latency SYNC_STAGES-1+DEBOUNCE_CYC = 5 edges after first sample
    din[0] = 1'b1;
    step(5);
    check("t1_level_early", 32'(lvl1), 32'h0);
    check("t1_pulse_early", 32'(pul1), 32'h0);
    step(1);
    check("t1_level", 32'(lvl1), 32'h1);
    check("t1_pulse", 32'(pul1), 32'h1);
    check("t1_busy",  32'(bsy1), 32'h1);
    step(1);
    check("t1_pulse_end", 32'(pul1), 32'h0);
    check("t1_busy_end",  32'(bsy1), 32'h0);
    check("t1_level_hold", 32'(lvl1), 32'h1);

    // 2: 3-cycle glitch on ch1 never gets through
    din[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t2_level", 32'(lvl1[1]), 32'h0);
      check("t2_pulse", 32'(pul1[1]), 32'h0);
    end
    din[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("t2_level", 32'(lvl1[1]), 32'h0);
      check("t2_pulse", 32'(pul1[1]), 32'h0);
    end

    // 3: ch2 both edges, PULSE_LEN=3
    din[2] = 1'b1;
    step(5);
    check("t3_pulse_early", 32'(pul3[2]), 32'h0);
    step(1);
    check("t3_rise_level", 32'(lvl3[2]), 32'h1);
    for (int i = 0; i < 3; i++) begin
      check("t3_rise_pulse", 32'(pul3[2]), 32'h1);
      step(1);
    end
    check("t3_rise_end", 32'(pul3[2]), 32'h0);
    check("t3_rise_busy_end", 32'(bsy3[2]), 32'h0);
    step(12);
    din[2] = 1'b0;
    step(5);
    check("t3_fall_level_early", 32'(lvl3[2]), 32'h1);
    check("t3_fall_pulse_early", 32'(pul3[2]), 32'h0);
    step(1);
    check("t3_fall_level", 32'(lvl3[2]), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("t3_fall_pulse", 32'(pul3[2]), 32'h1);
      step(1);
    end
    check("t3_fall_end", 32'(pul3[2]), 32'h0);

    // 3b: mode off: level follows, no pulse
    mode = 8'b11_11_00_00;
    din[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t3_off_pulse", 32'(pul3[2]), 32'h0);
    end
    check("t3_off_level_hi", 32'(lvl3[2]), 32'h1);
    din[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t3_off_pulse", 32'(pul3[2]), 32'h0);
    end
    check("t3_off_level_lo", 32'(lvl3[2]), 32'h0);

    // 4: PULSE_LEN=8, fall edge 4 cycles after rise on a both-mode channel -> 12 cycles
    mode = 8'b11_10_00_00;
    din[2] = 1'b1;
    step(4);
    din[2] = 1'b0;
    step(1);
    check("t4_pulse_early", 32'(pul8[2]), 32'h0);
    step(1);
    for (int i = 0; i < 12; i++) begin
      check("t4_pulse", 32'(pul8[2]), 32'h1);
      if (i == 4) check("t4_level_fell", 32'(lvl8[2]), 32'h0);
      step(1);
    end
    check("t4_pulse_end", 32'(pul8[2]), 32'h0);
    check("t4_busy_end",  32'(bsy8[2]), 32'h0);

    // 4b: clr mid-pulse
    din[2] = 1'b1;
    step(6);
    check("t4_clr_pre", 32'(pul8[2]), 32'h1);
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t4_clr_pulse", 32'(pul8[2]), 32'h0);
    check("t4_clr_busy",  32'(bsy8[2]), 32'h0);
    check("t4_clr_level", 32'(lvl8[2]), 32'h1);
    step(1);
    check("t4_clr_after", 32'(pul8[2]), 32'h0);

    // 5: all channels step together, modes rise/fall/both/off
    rst_n = 1'b0;
    din   = '0;
    step(2);
    check("t5_rst_level", 32'(lvl1), 32'h0);
    rst_n = 1'b1;
    mode  = 8'b11_10_01_00;
    din   = 4'b1111;
    step(5);
    check("t5_pulse_early", 32'(pul1), 32'h0);
    step(1);
    check("t5_level", 32'(lvl1), 32'hf);
    check("t5_pulse", 32'(pul1), 32'h5);
    check("t5_busy",  32'(bsy1), 32'h5);
    step(1);
    check("t5_pulse_end", 32'(pul1), 32'h0);

    // 5b: reset mid-debounce
    din = '0;
    step(7);
    din = 4'b1111;
    step(3);
    rst_n = 1'b0;
    din   = '0;
    step(1);
    check("t5_rst_level", 32'(lvl1), 32'h0);
    check("t5_rst_pulse", 32'(pul1), 32'h0);
    check("t5_rst_busy",  32'(bsy1), 32'h0);
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("t5_post_level", 32'(lvl1), 32'h0);
      check("t5_post_pulse", 32'(pul1), 32'h0);
    end

`ifdef EDGE_COUNT_EN
    // 6: saturating counter, CNT_W=3, ch3 rise
    mode = 8'b00_10_01_00;
    clr  = 1'b1;
    step(1);
    clr  = 1'b0;
    check("t6_cnt_init", 32'(cntc[9 +: 3]), 32'h0);
    for (int k = 1; k <= 9; k++) begin
      din[3] = 1'b1;
      step(6);
      din[3] = 1'b0;
      step(6);
      check("t6_cnt", 32'(cntc[9 +: 3]), (k > 7) ? 32'd7 : 32'(k));
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t6_cnt_clr", 32'(cntc[9 +: 3]), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
